// File: rtl/sprite_motion.sv
// Per-frame sprite position generator: steps (x,y) by (vx,vy) on each vsync rising edge,
// reflecting velocity at the playfield edges, with pause and synchronous load.
module sprite_motion #(
   parameter int MAX_X   = 200,
   parameter int MAX_Y   = 150,
   parameter int INIT_X  = 0,
   parameter int INIT_Y  = 0,
   parameter int INIT_VX = 3,
   parameter int INIT_VY = 2
) (
   input  logic               i_pix_clk,
   input  logic               i_reset,
   input  logic               i_vert_sync,
   input  logic               i_enable,
   input  logic               i_load,
   input  logic signed [15:0] i_load_x,
   input  logic signed [15:0] i_load_y,
   input  logic signed [15:0] i_load_vx,
   input  logic signed [15:0] i_load_vy,
   output logic signed [15:0] o_x_coord,
   output logic signed [15:0] o_y_coord,
   output logic signed [15:0] o_x_vel,
   output logic signed [15:0] o_y_vel,
   output logic               o_bounce_x,
   output logic               o_bounce_y,
   output logic               o_update
);

   typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y} state_t;

   localparam logic signed [16:0] LIM_X = 17'(MAX_X);
   localparam logic signed [16:0] LIM_Y = 17'(MAX_Y);

   state_t state_q, state_d;
   logic   vs_q, rise;
   logic signed [15:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
   logic   bx_pend_q, bx_pend_d;
   logic   bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d, update_q, update_d;
   logic signed [15:0] stx_pos, stx_vel, sty_pos, sty_vel;
   logic   stx_b, sty_b;

   // -32768 has no positive counterpart, so it is never stored
   function automatic logic signed [15:0] sat_vel(input logic signed [15:0] v);
      return (v == 16'sh8000) ? 16'sh8001 : v;
   endfunction

   function automatic void step_axis(
      input  logic signed [15:0] pos,
      input  logic signed [15:0] vel,
      input  logic signed [16:0] lim,
      output logic signed [15:0] pos_n,
      output logic signed [15:0] vel_n,
      output logic               bounce
   );
      logic signed [16:0] nxt;
      nxt    = {pos[15], pos} + {vel[15], vel};
      pos_n  = nxt[15:0];
      vel_n  = vel;
      bounce = 1'b0;
      if (nxt >= lim) begin
         pos_n  = 16'(lim - 17'sd1);
         vel_n  = sat_vel(-vel);
         bounce = 1'b1;
      end else if (nxt < 17'sd0) begin
         pos_n  = '0;
         vel_n  = sat_vel(-vel);
         bounce = 1'b1;
      end
   endfunction

   assign rise = i_vert_sync & ~vs_q;

   always_comb begin
      step_axis(x_q, vx_q, LIM_X, stx_pos, stx_vel, stx_b);
      step_axis(y_q, vy_q, LIM_Y, sty_pos, sty_vel, sty_b);
   end

   always_ff @(posedge i_pix_clk) begin
      if (i_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (i_load) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (rise && i_enable) state_d = STEP_X;
            STEP_X:  state_d = STEP_Y;
            STEP_Y:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      vx_d       = vx_q;
      vy_d       = vy_q;
      bx_pend_d  = bx_pend_q;
      bounce_x_d = 1'b0;
      bounce_y_d = 1'b0;
      update_d   = 1'b0;
      if (i_load) begin
         x_d       = i_load_x;
         y_d       = i_load_y;
         vx_d      = sat_vel(i_load_vx);
         vy_d      = sat_vel(i_load_vy);
         bx_pend_d = 1'b0;
      end else begin
         case (state_q)
            STEP_X: begin
               x_d       = stx_pos;
               vx_d      = stx_vel;
               bx_pend_d = stx_b;
            end
            STEP_Y: begin
               y_d        = sty_pos;
               vy_d       = sty_vel;
               bounce_x_d = bx_pend_q;
               bounce_y_d = sty_b;
               update_d   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // vsync history resets high so a vsync already high at reset release is not an edge
   always_ff @(posedge i_pix_clk) begin
      if (i_reset) begin
         vs_q       <= 1'b1;
         x_q        <= 16'(INIT_X);
         y_q        <= 16'(INIT_Y);
         vx_q       <= 16'(INIT_VX);
         vy_q       <= 16'(INIT_VY);
         bx_pend_q  <= 1'b0;
         bounce_x_q <= 1'b0;
         bounce_y_q <= 1'b0;
         update_q   <= 1'b0;
      end else begin
         vs_q       <= i_vert_sync;
         x_q        <= x_d;
         y_q        <= y_d;
         vx_q       <= vx_d;
         vy_q       <= vy_d;
         bx_pend_q  <= bx_pend_d;
         bounce_x_q <= bounce_x_d;
         bounce_y_q <= bounce_y_d;
         update_q   <= update_d;
      end
   end

   assign o_x_coord  = x_q;
   assign o_y_coord  = y_q;
   assign o_x_vel    = vx_q;
   assign o_y_vel    = vy_q;
   assign o_bounce_x = bounce_x_q;
   assign o_bounce_y = bounce_y_q;
   assign o_update   = update_q;

endmodule
